// File: rtl/sid_bus_regs.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | sid_bus_regs : SID register image, read-back mux and bus-value fade-out   |
// | Revision     : 1.0                                                        |
// +--------------------------------------------------------------------------+
module sid_bus_regs #(
  parameter int          VOICES   = 3,
  parameter int          NFILT    = 4,
  parameter int          NW       = VOICES * 7 + NFILT,
  parameter int          NR       = 4,
  parameter int          AW       = 5,
  parameter logic [23:0] TTL_6581 = 24'h001D00,
  parameter logic [23:0] TTL_8580 = 24'h0A2000,
  parameter logic [23:0] STAGGER  = 24'h000000
) (
  input  logic              clk,
  input  logic              res_n,
  input  logic              phi2,
  input  logic              model,
  input  logic              cs,
  input  logic              we,
  input  logic              oe,
  input  logic [AW-1:0]     addr,
  input  logic [7:0]        data_i,
  output logic [7:0]        data_o,
  output logic [8*NW-1:0]   wregs,
  input  logic [8*NR-1:0]   rregs,
  output logic              reg_wr,
  output logic [AW-1:0]     reg_wr_addr
);

  localparam logic [31:0] c_nw       = NW;
  localparam logic [31:0] c_nr       = NR;
  localparam logic [23:0] c_lim_6581 = 24'(TTL_6581 + 7 * STAGGER);
  localparam logic [23:0] c_lim_8580 = 24'(TTL_8580 + 7 * STAGGER);

  logic [1:0]      r_sync;
  logic [7:0]      r_data_o;
  logic [8*NW-1:0] r_wregs;
  logic            r_reg_wr;
  logic [AW-1:0]   r_reg_wr_addr;
  logic [7:0]      r_bus;
  logic [23:0]     r_age;

  logic [31:0] w_addr32;
  logic [31:0] w_ridx;
  logic        w_run;
  logic        w_strobe;
  logic        w_wr;
  logic        w_rd;
  logic        w_in_w;
  logic        w_wr_hit;
  logic [7:0]  w_rdata;
  logic [7:0]  w_mask;
  logic [7:0]  w_faded;
  logic [23:0] w_lim;

  assign w_addr32 = 32'(addr);
  assign w_ridx   = w_addr32 - c_nw;
  assign w_run    = r_sync[1];
  assign w_strobe = phi2 & w_run;
  assign w_wr     = cs & we;
  assign w_rd     = cs & oe & ~we & (w_addr32 >= c_nw) & (w_addr32 < c_nw + c_nr);
  assign w_in_w   = w_addr32 < c_nw;
  assign w_wr_hit = w_strobe & w_wr & w_in_w;
  assign w_lim    = model ? c_lim_8580 : c_lim_6581;
  assign w_faded  = r_bus & ~w_mask;

  always_comb begin
    w_rdata = 8'h00;
    for (int j = 0; j < NR; j++) begin
      if (w_ridx == 32'(j)) w_rdata = rregs[8*j +: 8];
    end
  end

  // Bit i of the floating bus dies once the age reaches its own staggered threshold.
  for (genvar i = 0; i < 8; i++) begin : g_mask
    localparam logic [23:0] c_thr_6581 = 24'(TTL_6581 + i * STAGGER);
    localparam logic [23:0] c_thr_8580 = 24'(TTL_8580 + i * STAGGER);
    assign w_mask[i] = model ? (r_age >= c_thr_8580) : (r_age >= c_thr_6581);
  end

  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) r_sync <= 2'b00;
    else        r_sync <= {r_sync[0], 1'b1};
  end

  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      r_wregs       <= '0;
      r_reg_wr      <= 1'b0;
      r_reg_wr_addr <= '0;
    end else begin
      r_reg_wr <= w_wr_hit;
      if (w_wr_hit) begin
        r_reg_wr_addr <= addr;
        for (int k = 0; k < NW; k++) begin
          if (w_addr32 == 32'(k)) r_wregs[8*k +: 8] <= data_i;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      r_bus <= 8'h00;
      r_age <= 24'h000000;
    end else if (w_strobe) begin
      if (w_rd) begin
        r_bus <= w_rdata;
        r_age <= 24'h000000;
      end else if (w_wr) begin
        r_bus <= data_i;
        r_age <= 24'h000000;
      end else begin
        if (&w_mask)       r_bus <= 8'h00;
        if (r_age < w_lim) r_age <= r_age + 24'd1;
      end
    end
  end

  // Read-back path runs every clock, independent of the bus strobe.
  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n)    r_data_o <= 8'h00;
    else if (w_rd) r_data_o <= w_rdata;
    else           r_data_o <= w_faded;
  end

  assign data_o      = r_data_o;
  assign wregs       = r_wregs;
  assign reg_wr      = r_reg_wr;
  assign reg_wr_addr = r_reg_wr_addr;

endmodule
`default_nettype wire
